sha256_msg_sched: RTL and testbench

- Upstream feeder for the SHA-256 round compressor.
- Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready handshake.
- Expands the block into the 64-word message schedule W_t.
- Emits one round per cycle: round index, W_t and the matching round constant K_t. Also produces the load pulse that makes the compressor latch its H inputs.

---
 rtl/sha256_msg_sched_if.sv | 40 ++++
 rtl/sha256_msg_sched.sv | 186 ++++++++++++++++++
 tb/tb_sha256_msg_sched.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_sched_if
// Brief    : Message-word input and round-output bundle of sha256_msg_sched.
//            STALL exists only when SCHED_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_msg_sched_if;
  logic        WORD_VALID;
  logic [31:0] WORD_IN;
  logic        WORD_READY;
  logic        INIT;
  logic        ROUND_VALID;
  logic [5:0]  I;
  logic [31:0] W_OUT;
  logic [31:0] K_OUT;
  logic        DONE;
`ifdef SCHED_STALL_EN
  logic        STALL;

  modport master (
    output WORD_VALID, WORD_IN, STALL,
    input  WORD_READY, INIT, ROUND_VALID, I, W_OUT, K_OUT, DONE
  );
  modport slave (
    input  WORD_VALID, WORD_IN, STALL,
    output WORD_READY, INIT, ROUND_VALID, I, W_OUT, K_OUT, DONE
  );
`else
  modport master (
    output WORD_VALID, WORD_IN,
    input  WORD_READY, INIT, ROUND_VALID, I, W_OUT, K_OUT, DONE
  );
  modport slave (
    input  WORD_VALID, WORD_IN,
    output WORD_READY, INIT, ROUND_VALID, I, W_OUT, K_OUT, DONE
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_sched
// Brief    : SHA-256 message scheduler; loads 16 words, emits W_t/K_t for 64
//            rounds. Optional macro SCHED_STALL_EN adds the STALL input.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_sched #(
  parameter int K_ROM_DEPTH = 64
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  sha256_msg_sched_if.slave  bus
);

  generate
    if (K_ROM_DEPTH != 64) begin : g_bad_depth
      $error("sha256_msg_sched: K_ROM_DEPTH must be 64");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PRIME  = 3'd2;
  localparam logic [2:0] S_ROUNDS = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [31:0] c_k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] f_rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] f_s0(input logic [31:0] x);
    return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1(input logic [31:0] x);
    return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [3:0]  r_cnt;
  logic [5:0]  r_t;
  logic [31:0] r_buf [0:15];

  logic        w_stall;
  logic        w_word_ready;
  logic        w_xfer;
  logic [3:0]  w_t4;
  logic [3:0]  w_ix2;
  logic [3:0]  w_ix7;
  logic [3:0]  w_ix15;
  logic [31:0] w_sched;

`ifdef SCHED_STALL_EN
  assign w_stall = bus.STALL;
`else
  assign w_stall = 1'b0;
`endif

  assign w_word_ready = ((r_state == S_IDLE) || (r_state == S_LOAD)) && !RESET;
  assign w_xfer       = bus.WORD_VALID && w_word_ready;

  // The circular buffer holds W(t-16)..W(t-1); 4-bit index arithmetic wraps mod 16.
  assign w_t4   = r_t[3:0];
  assign w_ix2  = w_t4 - 4'd2;
  assign w_ix7  = w_t4 - 4'd7;
  assign w_ix15 = w_t4 + 4'd1;

  always_comb begin
    w_sched = r_buf[w_t4];
    if (r_t[5:4] != 2'b00) begin
      w_sched = f_s1(r_buf[w_ix2]) + r_buf[w_ix7] + f_s0(r_buf[w_ix15]) + r_buf[w_t4];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_next_state = S_LOAD;
      S_LOAD:   if (w_xfer && (r_cnt == 4'd15)) w_next_state = S_PRIME;
      S_PRIME:  if (!w_stall) w_next_state = S_ROUNDS;
      S_ROUNDS: if (!w_stall && (r_t == 6'd63)) w_next_state = S_FIN;
      S_FIN:    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= 4'd0;
      r_t   <= 6'd0;
      for (int j = 0; j < 16; j++) begin
        r_buf[j] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_buf[0] <= bus.WORD_IN;
            r_cnt    <= 4'd1;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_buf[r_cnt] <= bus.WORD_IN;
            r_cnt        <= r_cnt + 4'd1;
          end
        end
        S_PRIME: begin
          r_t <= 6'd0;
        end
        S_ROUNDS: begin
          // Overwrites W(t-16), the oldest entry, which this round has just consumed.
          if (!w_stall) begin
            r_buf[w_t4] <= w_sched;
            if (r_t != 6'd63) begin
              r_t <= r_t + 6'd1;
            end
          end
        end
        S_FIN: begin
          r_t <= 6'd0;
        end
        default: begin
          r_t <= 6'd0;
        end
      endcase
    end
  end

  always_comb begin
    bus.WORD_READY  = w_word_ready;
    bus.INIT        = 1'b0;
    bus.ROUND_VALID = 1'b0;
    bus.I           = r_t;
    bus.W_OUT       = 32'd0;
    bus.K_OUT       = 32'd0;
    bus.DONE        = 1'b0;
    case (r_state)
      S_PRIME: begin
        bus.INIT = !w_stall;
      end
      S_ROUNDS: begin
        bus.ROUND_VALID = !w_stall;
        bus.W_OUT       = w_sched;
        bus.K_OUT       = c_k[r_t];
      end
      S_FIN: begin
        bus.DONE = 1'b1;
      end
      default: begin
        bus.DONE = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`default_nettype none
// Bench for sha256_msg_sched: scoreboard of golden W/K per round, timing
// referenced to acceptance of the 16th word. STALL tests need SCHED_STALL_EN.
`timescale 1ns/1ps
module tb_sha256_msg_sched;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  sha256_msg_sched_if bus ();

  sha256_msg_sched #(.K_ROM_DEPTH(64)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  localparam logic [31:0] GOLD_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [5:0]  i;
    logic [31:0] w;
    logic [31:0] k;
  } rnd_t;

  rnd_t        sb_q [$];
  logic [31:0] cur_blk [16];
  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic void push_expected();
    logic [31:0] w [64];
    rnd_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = cur_blk[t];
      else        w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
      e.i = 6'(t);
      e.w = w[t];
      e.k = GOLD_K[t];
      sb_q.push_back(e);
    end
  endfunction

  task automatic load_abc();
    for (int n = 0; n < 16; n++) cur_blk[n] = 32'd0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
  endtask

  task automatic load_random();
    for (int n = 0; n < 16; n++) cur_blk[n] = $urandom;
  endtask

  // Called just after a falling edge; returns at the falling edge after word 15 is accepted.
  task automatic send_block(input int gap_at, input int gap_len);
    push_expected();
    for (int n = 0; n < 16; n++) begin
      if (n == gap_at) begin
        bus.WORD_VALID = 1'b0;
        repeat (gap_len) @(negedge CLK);
      end
      bus.WORD_VALID = 1'b1;
      bus.WORD_IN    = cur_blk[n];
      #1;
      n_checks++;
      if (bus.WORD_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL word_ready word%0d: got %b want 1", n, bus.WORD_READY);
      end
      @(negedge CLK);
    end
    bus.WORD_VALID = 1'b0;
  endtask

  task automatic run_rounds(input int stall_at, input int stall_len, input bit hold_valid, input int abort_at);
    int   c;
    int   stall_left;
    bit   stall_pending;
    bit   done_seen;
    rnd_t e;
    c = 0;
    stall_left = 0;
    stall_pending = (stall_len > 0);
    done_seen = 1'b0;
    for (int n = 0; n < 64; n++) begin
      obs_w[n] = 32'd0;
      obs_k[n] = 32'd0;
    end
    if (hold_valid) begin
      bus.WORD_VALID = 1'b1;
      bus.WORD_IN    = 32'hDEADBEEF;
    end
    while (!done_seen && c < 200) begin
      c++;
`ifdef SCHED_STALL_EN
      if (stall_left == 0) bus.STALL = 1'b0;
      if (stall_pending && bus.ROUND_VALID === 1'b1 && int'(bus.I) == stall_at) begin
        bus.STALL     = 1'b1;
        stall_left    = stall_len;
        stall_pending = 1'b0;
      end
`endif
      #1;
      if (c == 1) begin
        n_checks++;
        if (bus.INIT !== 1'b1 || bus.ROUND_VALID !== 1'b0 || bus.WORD_READY !== 1'b0) begin
          n_fail++;
          $display("FAIL init_cycle: got INIT=%b RV=%b WR=%b want 1 0 0", bus.INIT, bus.ROUND_VALID, bus.WORD_READY);
        end
      end else if (stall_left > 0) begin
        n_checks++;
        if (bus.ROUND_VALID !== 1'b0 || int'(bus.I) != stall_at || sb_q.size() == 0 ||
            bus.W_OUT !== sb_q[0].w || bus.K_OUT !== sb_q[0].k) begin
          n_fail++;
          $display("FAIL stall_hold: got RV=%b I=%0d W=%h K=%h want RV=0 I=%0d held W/K", bus.ROUND_VALID, bus.I, bus.W_OUT, bus.K_OUT, stall_at);
        end
        stall_left--;
      end else if (bus.ROUND_VALID === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL round_extra: got I=%0d want no round", bus.I);
        end else begin
          e = sb_q.pop_front();
          obs_w[e.i] = bus.W_OUT;
          obs_k[e.i] = bus.K_OUT;
          if (bus.I !== e.i || bus.W_OUT !== e.w || bus.K_OUT !== e.k || bus.WORD_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL round: got I=%0d W=%h K=%h WR=%b want I=%0d W=%h K=%h WR=0", bus.I, bus.W_OUT, bus.K_OUT, bus.WORD_READY, e.i, e.w, e.k);
          end
          if (int'(e.i) == abort_at) begin
            RESET = 1'b1;
            @(negedge CLK);
            #1;
            n_checks++;
            if (bus.DONE !== 1'b0 || bus.ROUND_VALID !== 1'b0 || bus.WORD_READY !== 1'b0) begin
              n_fail++;
              $display("FAIL abort_reset1: got DONE=%b RV=%b WR=%b want 0 0 0", bus.DONE, bus.ROUND_VALID, bus.WORD_READY);
            end
            @(negedge CLK);
            #1;
            n_checks++;
            if (bus.DONE !== 1'b0 || bus.INIT !== 1'b0 || bus.I !== 6'd0 || bus.W_OUT !== 32'd0 || bus.K_OUT !== 32'd0) begin
              n_fail++;
              $display("FAIL abort_reset2: got DONE=%b INIT=%b I=%0d W=%h K=%h want all 0", bus.DONE, bus.INIT, bus.I, bus.W_OUT, bus.K_OUT);
            end
            RESET = 1'b0;
            sb_q.delete();
            @(negedge CLK);
            #1;
            n_checks++;
            if (bus.WORD_READY !== 1'b1 || bus.DONE !== 1'b0) begin
              n_fail++;
              $display("FAIL abort_recover: got WR=%b DONE=%b want 1 0", bus.WORD_READY, bus.DONE);
            end
            return;
          end
        end
      end else if (bus.DONE === 1'b1) begin
        done_seen = 1'b1;
        bus.WORD_VALID = 1'b0;
        n_checks++;
        if (c != 66 + stall_len || bus.I !== 6'd63 || sb_q.size() != 0) begin
          n_fail++;
          $display("FAIL done_timing: got cycle=%0d I=%0d left=%0d want cycle=%0d I=63 left=0", c, bus.I, sb_q.size(), 66 + stall_len);
        end
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL round_gap: got no ROUND_VALID/DONE at cycle %0d want activity", c);
      end
      if (!done_seen) @(negedge CLK);
    end
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no DONE within %0d cycles want DONE", c);
      return;
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if (bus.WORD_READY !== 1'b1 || bus.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL post_fin: got WR=%b DONE=%b want 1 0", bus.WORD_READY, bus.DONE);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    n_checks++;
    if (bus.WORD_READY !== 1'b0 || bus.INIT !== 1'b0 || bus.ROUND_VALID !== 1'b0 || bus.I !== 6'd0 ||
        bus.W_OUT !== 32'd0 || bus.K_OUT !== 32'd0 || bus.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got WR=%b INIT=%b RV=%b I=%0d W=%h K=%h DONE=%b want all 0",
               bus.WORD_READY, bus.INIT, bus.ROUND_VALID, bus.I, bus.W_OUT, bus.K_OUT, bus.DONE);
    end
    RESET = 1'b0;
    @(negedge CLK);
    #1;
    n_checks++;
    if (bus.WORD_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got WR=%b want 1", bus.WORD_READY);
    end
  endtask

  task automatic test_abc();
    load_abc();
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b0, -1);
    n_checks++;
    if (obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000F0000) begin
      n_fail++;
      $display("FAIL abc_w16_17: got %h %h want 61626380 000f0000", obs_w[16], obs_w[17]);
    end
    n_checks++;
    if (obs_k[0] !== 32'h428A2F98 || obs_k[63] !== 32'hC67178F2) begin
      n_fail++;
      $display("FAIL abc_k0_63: got %h %h want 428a2f98 c67178f2", obs_k[0], obs_k[63]);
    end
  endtask

  task automatic test_gaps();
    load_abc();
    send_block(8, 3);
    run_rounds(-1, 0, 1'b0, -1);
  endtask

  task automatic test_words_during_rounds();
    load_abc();
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b1, -1);
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    load_random();
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b0, 30);
    load_abc();
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    load_random();
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b0, -1);
    load_random();
    send_block(-1, 0);
    run_rounds(-1, 0, 1'b0, -1);
  endtask

`ifdef SCHED_STALL_EN
  task automatic test_stall();
    load_abc();
    send_block(-1, 0);
    run_rounds(20, 5, 1'b0, -1);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    RESET = 1'b1;
    bus.WORD_VALID = 1'b0;
    bus.WORD_IN = 32'd0;
`ifdef SCHED_STALL_EN
    bus.STALL = 1'b0;
`endif
    test_reset();
    test_abc();
    test_gaps();
    test_words_during_rounds();
    test_reset_mid();
    test_back_to_back();
`ifdef SCHED_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
